// File: rtl/jls_pkg.sv
// Shared constants, bias-correction encodings and width helpers for the
// JPEG-LS prediction-error pipeline.
package jls_pkg;

    typedef enum logic [1:0] {
        DC_NONE = 2'b00,
        DC_INC  = 2'b01,
        DC_DEC  = 2'b11
    } dc_e;

    function automatic int calc_maxval(input int bpp);
        return (1 << bpp) - 1;
    endfunction

    function automatic int calc_range(input int bpp, input int near);
        return (calc_maxval(bpp) + 2 * near) / (2 * near + 1) + 1;
    endfunction

    function automatic int calc_qbpp(input int bpp, input int near);
        return $clog2(calc_range(bpp, near));
    endfunction

    // Signed width that holds every intermediate value of the error path.
    function automatic int calc_arith_w(input int bpp, input int cw);
        return bpp + cw + 3;
    endfunction

    // The unused code 2'b10 behaves as "no correction".
    function automatic dc_e dc_norm(input logic [1:0] raw);
        case (raw)
            2'b01:   return DC_INC;
            2'b11:   return DC_DEC;
            default: return DC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/errval_core.sv
// Combinational prediction correction, clamp, error quantisation,
// reconstruction and modulo reduction for one bias candidate.
module errval_core
    import jls_pkg::*;
#(
    parameter int BPP  = 8,
    parameter int NEAR = 0,
    parameter int CW   = 8
) (
    input  logic                 sign,
    input  logic signed [CW:0]   ck,
    input  logic [BPP-1:0]       ix,
    input  logic [BPP-1:0]       px,
    output logic signed [BPP:0]  errval,
    output logic [BPP-1:0]       rx
);

    localparam int W      = calc_arith_w(BPP, CW);
    localparam int MAXVAL = calc_maxval(BPP);
    localparam int RANGE  = calc_range(BPP, NEAR);
    localparam int QSTEP  = 2 * NEAR + 1;

    typedef logic signed [W-1:0] sw_t;

    localparam sw_t MAXVAL_W = sw_t'(MAXVAL);
    localparam sw_t NEAR_W   = sw_t'(NEAR);
    localparam sw_t QSTEP_W  = sw_t'(QSTEP);
    localparam sw_t RANGE_W  = sw_t'(RANGE);
    localparam sw_t HALF_W   = sw_t'((RANGE + 1) / 2);
    localparam sw_t WRAP_W   = sw_t'(RANGE * QSTEP);
    localparam sw_t HI_W     = sw_t'(MAXVAL + NEAR);

    typedef struct packed {
        logic [BPP:0]   errval;
        logic [BPP-1:0] rx;
    } res_t;

    function automatic res_t calc(input logic sgn, input logic signed [CW:0] c_k,
                                  input logic [BPP-1:0] x, input logic [BPP-1:0] p);
        sw_t  pw, xw, cw_w, pc, e, rxw;
        res_t r;
        pw   = sw_t'(p);
        xw   = sw_t'(x);
        cw_w = sw_t'(c_k);

        pc = sgn ? pw - cw_w : pw + cw_w;
        if (pc < 0)
            pc = '0;
        else if (pc > MAXVAL_W)
            pc = MAXVAL_W;

        e = sgn ? pc - xw : xw - pc;
        // Operands of the divide are kept non-negative so truncation is symmetric.
        if (NEAR > 0) begin
            if (e > 0)
                e = (NEAR_W + e) / QSTEP_W;
            else
                e = -((NEAR_W - e) / QSTEP_W);
        end

        rxw = pc + (sgn ? -e : e) * QSTEP_W;
        if (rxw < -NEAR_W)
            rxw = rxw + WRAP_W;
        else if (rxw > HI_W)
            rxw = rxw - WRAP_W;
        if (rxw < 0)
            rxw = '0;
        else if (rxw > MAXVAL_W)
            rxw = MAXVAL_W;

        if (e < 0)
            e = e + RANGE_W;
        if (e >= HALF_W)
            e = e - RANGE_W;

        r.errval = e[BPP:0];
        r.rx     = rxw[BPP-1:0];
        return r;
    endfunction

    res_t res;

    always_comb begin
        res = calc(sign, ck, ix, px);
    end

    assign errval = res.errval;
    assign rx     = res.rx;

endmodule

// File: rtl/errval_pipe.sv
// Two-stage JPEG-LS prediction-error stage with same-context bias forwarding:
// S1 evaluates C, C+1 and C-1 in parallel, the transfer to S2 picks one.
module errval_pipe
    import jls_pkg::*;
#(
    parameter int BPP  = 8,
    parameter int NEAR = 0,
    parameter int CW   = 8,
    parameter int QW   = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [QW-1:0]       in_q,
    input  logic                in_sign,
    input  logic [CW-1:0]       in_c,
    input  logic [BPP-1:0]      in_ix,
    input  logic [BPP-1:0]      in_px,
    input  logic                fwd_valid,
    input  logic [QW-1:0]       fwd_q,
    input  logic [1:0]          fwd_dc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [QW-1:0]       out_q,
    output logic                out_sign,
    output logic signed [BPP:0] out_errval,
    output logic [BPP-1:0]      out_rx,
    output logic                out_fwd
);

    localparam logic signed [CW:0] ONE = 1;

    logic                s1_valid_q, s1_valid_d;
    logic [QW-1:0]       s1_q_q, s1_q_d;
    logic                s1_sign_q, s1_sign_d;
    logic [CW-1:0]       s1_c_q, s1_c_d;
    logic [BPP-1:0]      s1_ix_q, s1_ix_d;
    logic [BPP-1:0]      s1_px_q, s1_px_d;
    dc_e                 s1_dc_q, s1_dc_d;

    logic                s2_valid_q, s2_valid_d;
    logic [QW-1:0]       s2_q_q, s2_q_d;
    logic                s2_sign_q, s2_sign_d;
    logic signed [BPP:0] s2_errval_q, s2_errval_d;
    logic [BPP-1:0]      s2_rx_q, s2_rx_d;
    logic                s2_fwd_q, s2_fwd_d;

    logic                s1_load, s2_load;
    logic                s1_match, in_match;
    dc_e                 dc_fwd, dc_eff;
    logic signed [CW:0]  c_ext;
    logic signed [CW:0]  cand_ck  [3];
    logic signed [BPP:0] cand_err [3];
    logic [BPP-1:0]      cand_rx  [3];
    logic signed [BPP:0] sel_err;
    logic [BPP-1:0]      sel_rx;

    always_comb begin
        c_ext      = {s1_c_q[CW-1], s1_c_q};
        cand_ck[0] = c_ext;
        cand_ck[1] = c_ext + ONE;
        cand_ck[2] = c_ext - ONE;
    end

    for (genvar k = 0; k < 3; k++) begin : g_cand
        errval_core #(
            .BPP  (BPP),
            .NEAR (NEAR),
            .CW   (CW)
        ) u_core (
            .sign   (s1_sign_q),
            .ck     (cand_ck[k]),
            .ix     (s1_ix_q),
            .px     (s1_px_q),
            .errval (cand_err[k]),
            .rx     (cand_rx[k])
        );
    end

    // A correction committed this cycle overrides whatever the sticky holds.
    always_comb begin
        dc_fwd   = dc_norm(fwd_dc);
        s1_match = s1_valid_q && fwd_valid && (fwd_q == s1_q_q) && (dc_fwd != DC_NONE);
        in_match = in_valid && fwd_valid && (fwd_q == in_q) && (dc_fwd != DC_NONE);
        dc_eff   = s1_match ? dc_fwd : s1_dc_q;
        s2_load  = !s2_valid_q || out_ready;
        s1_load  = !s1_valid_q || s2_load;
        case (dc_eff)
            DC_INC: begin
                sel_err = cand_err[1];
                sel_rx  = cand_rx[1];
            end
            DC_DEC: begin
                sel_err = cand_err[2];
                sel_rx  = cand_rx[2];
            end
            default: begin
                sel_err = cand_err[0];
                sel_rx  = cand_rx[0];
            end
        endcase
    end

    // NOTE: every _d starts from its _q so no path leaves a variable unassigned (no latches).
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_q_d      = s1_q_q;
        s1_sign_d   = s1_sign_q;
        s1_c_d      = s1_c_q;
        s1_ix_d     = s1_ix_q;
        s1_px_d     = s1_px_q;
        s1_dc_d     = s1_dc_q;
        s2_valid_d  = s2_valid_q;
        s2_q_d      = s2_q_q;
        s2_sign_d   = s2_sign_q;
        s2_errval_d = s2_errval_q;
        s2_rx_d     = s2_rx_q;
        s2_fwd_d    = s2_fwd_q;

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_q_d      = s1_q_q;
                s2_sign_d   = s1_sign_q;
                s2_errval_d = sel_err;
                s2_rx_d     = sel_rx;
                s2_fwd_d    = (dc_eff != DC_NONE);
            end
        end

        if (s1_load) begin
            s1_valid_d = in_valid;
            s1_dc_d    = in_match ? dc_fwd : DC_NONE;
            if (in_valid) begin
                s1_q_d    = in_q;
                s1_sign_d = in_sign;
                s1_c_d    = in_c;
                s1_ix_d   = in_ix;
                s1_px_d   = in_px;
            end
        end else if (s1_match) begin
            s1_dc_d = dc_fwd;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    // NOTE: data registers are reset too, because the outputs must read 0 while in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_q_q      <= '0;
            s1_sign_q   <= 1'b0;
            s1_c_q      <= '0;
            s1_ix_q     <= '0;
            s1_px_q     <= '0;
            s1_dc_q     <= DC_NONE;
            s2_valid_q  <= 1'b0;
            s2_q_q      <= '0;
            s2_sign_q   <= 1'b0;
            s2_errval_q <= '0;
            s2_rx_q     <= '0;
            s2_fwd_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q_q      <= s1_q_d;
            s1_sign_q   <= s1_sign_d;
            s1_c_q      <= s1_c_d;
            s1_ix_q     <= s1_ix_d;
            s1_px_q     <= s1_px_d;
            s1_dc_q     <= s1_dc_d;
            s2_valid_q  <= s2_valid_d;
            s2_q_q      <= s2_q_d;
            s2_sign_q   <= s2_sign_d;
            s2_errval_q <= s2_errval_d;
            s2_rx_q     <= s2_rx_d;
            s2_fwd_q    <= s2_fwd_d;
        end
    end

    assign in_ready   = s1_load;
    assign out_valid  = s2_valid_q;
    assign out_q      = s2_q_q;
    assign out_sign   = s2_sign_q;
    assign out_errval = s2_errval_q;
    assign out_rx     = s2_rx_q;
    assign out_fwd    = s2_fwd_q;

endmodule

// File: tb/tb_errval_pipe.sv
// Directed bench for errval_pipe: a lossless and a NEAR=2 instance share stimulus.
module tb_errval_pipe;

    localparam int BPP = 8;
    localparam int CW  = 8;
    localparam int QW  = 9;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                in_valid = 1'b0;
    logic [QW-1:0]       in_q = '0;
    logic                in_sign = 1'b0;
    logic [CW-1:0]       in_c = '0;
    logic [BPP-1:0]      in_ix = '0;
    logic [BPP-1:0]      in_px = '0;
    logic                fwd_valid = 1'b0;
    logic [QW-1:0]       fwd_q = '0;
    logic [1:0]          fwd_dc = '0;
    logic                out_ready = 1'b1;

    logic                o0_in_ready, o0_valid, o0_sign, o0_fwd;
    logic [QW-1:0]       o0_q;
    logic signed [BPP:0] o0_errval;
    logic [BPP-1:0]      o0_rx;
    logic                o2_in_ready, o2_valid, o2_sign, o2_fwd;
    logic [QW-1:0]       o2_q;
    logic signed [BPP:0] o2_errval;
    logic [BPP-1:0]      o2_rx;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    errval_pipe #(.BPP(BPP), .NEAR(0), .CW(CW), .QW(QW)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(o0_in_ready),
        .in_q(in_q), .in_sign(in_sign), .in_c(in_c), .in_ix(in_ix), .in_px(in_px),
        .fwd_valid(fwd_valid), .fwd_q(fwd_q), .fwd_dc(fwd_dc),
        .out_valid(o0_valid), .out_ready(out_ready),
        .out_q(o0_q), .out_sign(o0_sign), .out_errval(o0_errval),
        .out_rx(o0_rx), .out_fwd(o0_fwd)
    );

    errval_pipe #(.BPP(BPP), .NEAR(2), .CW(CW), .QW(QW)) u_dut_n2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(o2_in_ready),
        .in_q(in_q), .in_sign(in_sign), .in_c(in_c), .in_ix(in_ix), .in_px(in_px),
        .fwd_valid(fwd_valid), .fwd_q(fwd_q), .fwd_dc(fwd_dc),
        .out_valid(o2_valid), .out_ready(out_ready),
        .out_q(o2_q), .out_sign(o2_sign), .out_errval(o2_errval),
        .out_rx(o2_rx), .out_fwd(o2_fwd)
    );

    typedef struct {
        int q, sign, c, ix, px;
        int mode;      // 0 no forward, 1 forward in load cycle, 2 forward while in S1
        int fq, fdc;
        int e0, rx0, f;
        int e2, rx2;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_sample(input int q, input int sgn, input int c, input int ix, input int px);
        in_valid = 1'b1;
        in_q     = q[QW-1:0];
        in_sign  = sgn[0];
        in_c     = c[CW-1:0];
        in_ix    = ix[BPP-1:0];
        in_px    = px[BPP-1:0];
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        @(posedge clk); #1;
        drive_sample(v.q, v.sign, v.c, v.ix, v.px);
        fwd_q     = v.fq[QW-1:0];
        fwd_dc    = v.fdc[1:0];
        fwd_valid = (v.mode == 1);
        @(negedge clk);
        check({t, "_in_ready"}, int'(o0_in_ready), 1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        fwd_valid = (v.mode == 2);
        @(negedge clk);
        check({t, "_lat1_valid"}, int'(o0_valid), 0);
        @(posedge clk); #1;
        fwd_valid = 1'b0;
        @(negedge clk);
        check({t, "_valid"}, int'(o0_valid), 1);
        check({t, "_q"}, int'(o0_q), v.q);
        check({t, "_sign"}, int'(o0_sign), v.sign);
        check({t, "_errval"}, int'(o0_errval), v.e0);
        check({t, "_rx"}, int'(o0_rx), v.rx0);
        check({t, "_fwd"}, int'(o0_fwd), v.f);
        check({t, "_n2_errval"}, int'(o2_errval), v.e2);
        check({t, "_n2_rx"}, int'(o2_rx), v.rx2);
    endtask

    task automatic check_reset_outputs(input string t);
        check({t, "_valid"}, int'(o0_valid), 0);
        check({t, "_errval"}, int'(o0_errval), 0);
        check({t, "_rx"}, int'(o0_rx), 0);
        check({t, "_q"}, int'(o0_q), 0);
        check({t, "_sign"}, int'(o0_sign), 0);
        check({t, "_fwd"}, int'(o0_fwd), 0);
        check({t, "_n2_valid"}, int'(o2_valid), 0);
    endtask

    initial begin
        int n_in, n_out;
        //              q sg   c  ix   px md fq fdc  e0 rx0 f  e2 rx2
        vecs[0]  = '{7, 0,   5, 110, 100, 0, 0, 0,   5, 110, 0,  1, 110};
        vecs[1]  = '{3, 0,   0, 250,   3, 0, 0, 0,  -9, 250, 0, -3, 248};
        vecs[2]  = '{4, 0,  20,  10, 250, 0, 0, 0,  11,  10, 0,  3,  10};
        vecs[3]  = '{5, 1,   5,  90, 100, 0, 0, 0,   5,  90, 0,  1,  90};
        vecs[4]  = '{7, 0,   5, 110, 100, 2, 7, 1,   4, 110, 1,  1, 111};
        vecs[5]  = '{7, 0,   5, 110, 100, 2, 8, 1,   5, 110, 0,  1, 110};
        vecs[6]  = '{7, 0,   5, 110, 100, 1, 7, 3,   6, 110, 1,  1, 109};
        vecs[7]  = '{7, 0,   5, 110, 100, 2, 7, 2,   5, 110, 0,  1, 110};
        vecs[8]  = '{1, 0,   0, 107, 100, 0, 0, 0,   7, 107, 0,  1, 105};
        vecs[9]  = '{1, 0,   0, 255,   0, 0, 0, 0,  -1, 255, 0, -1, 255};
        vecs[10] = '{1, 0,   0,   0, 255, 0, 0, 0,   1,   0, 0,  1,   0};
        vecs[11] = '{2, 0, -10,   0,   5, 0, 0, 0,   0,   0, 0,  0,   0};
        vecs[12] = '{6, 1,   5,  90, 100, 1, 6, 1,   4,  90, 1,  1,  89};

        #12;
        check_reset_outputs("por");
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 13; i++) apply_vec(i, vecs[i]);

        // Correction arriving while the item is parked in S1 must stick.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive_sample(1, 0, 0, 101, 100);
        @(posedge clk); #1;
        drive_sample(9, 0, 5, 110, 100);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        fwd_valid = 1'b1;
        fwd_q     = 9;
        fwd_dc    = 2'b11;
        @(negedge clk);
        check("sticky_in_ready", int'(o0_in_ready), 0);
        @(posedge clk); #1;
        fwd_dc = 2'b10;
        @(posedge clk); #1;
        fwd_valid = 1'b0;
        @(negedge clk);
        check("sticky_hold_valid", int'(o0_valid), 1);
        check("sticky_hold_errval", int'(o0_errval), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("sticky_first_errval", int'(o0_errval), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("sticky_q", int'(o0_q), 9);
        check("sticky_errval", int'(o0_errval), 6);
        check("sticky_fwd", int'(o0_fwd), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("sticky_drain_valid", int'(o0_valid), 0);

        // Backpressure: three samples offered against a five-cycle stall.
        n_in  = 0;
        n_out = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 30 && n_out < 3; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 5) out_ready = 1'b1;
            if (n_in < 3) drive_sample(n_in, 0, 0, 101 + n_in, 100);
            else in_valid = 1'b0;
            @(negedge clk);
            if (cyc >= 2 && cyc < 5) begin
                check($sformatf("stall_hold_valid_c%0d", cyc), int'(o0_valid), 1);
                check($sformatf("stall_hold_errval_c%0d", cyc), int'(o0_errval), 1);
            end
            if (cyc == 4) begin
                check("stall_accepted", n_in, 2);
                check("stall_in_ready", int'(o0_in_ready), 0);
            end
            if (o0_valid && out_ready) begin
                check($sformatf("stall_out%0d_errval", n_out), int'(o0_errval), n_out + 1);
                check($sformatf("stall_out%0d_rx", n_out), int'(o0_rx), 101 + n_out);
                n_out++;
            end
            if (in_valid && o0_in_ready) n_in++;
        end
        in_valid = 1'b0;
        check("stall_total_in", n_in, 3);
        check("stall_total_out", n_out, 3);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_no_dup", int'(o0_valid), 0);

        // Reset with two samples in flight.
        out_ready = 1'b0;
        @(posedge clk); #1;
        drive_sample(1, 0, 0, 101, 100);
        @(posedge clk); #1;
        drive_sample(2, 0, 0, 102, 100);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_inflight_valid", int'(o0_valid), 1);
        check("rst_inflight_ready", int'(o0_in_ready), 0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        apply_vec(100, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
